// File: rtl/comm_fpga_fx2_param_if.sv
// Channel-side bundle of the FX2 bridge: channel address, host->FPGA pipe,
// FPGA->host pipe, transfer status and a debug view of the bridge FSM.
interface comm_fpga_fx2_param_if #(
  parameter int CHAN_WIDTH = 7
);
  logic [CHAN_WIDTH-1:0] chanAddr_out;
  logic [7:0]            h2fData_out;
  logic                  h2fValid_out;
  logic                  h2fReady_in;
  logic [7:0]            f2hData_in;
  logic                  f2hValid_in;
  logic                  f2hReady_out;
  logic                  xferBusy_out;
  logic                  xferDone_out;
  logic [3:0]            state_dbg;

  // An h2f byte moves on the edge where h2fValid_out=1 (valid is raised only while
  // h2fReady_in=1); an f2h byte moves on the edge where f2hValid_in & f2hReady_out.
  modport master (
    output chanAddr_out, h2fData_out, h2fValid_out, f2hReady_out,
    output xferBusy_out, xferDone_out, state_dbg,
    input  h2fReady_in, f2hData_in, f2hValid_in
  );

  modport slave (
    input  chanAddr_out, h2fData_out, h2fValid_out, f2hReady_out,
    input  xferBusy_out, xferDone_out, state_dbg,
    output h2fReady_in, f2hData_in, f2hValid_in
  );
endinterface

// File: rtl/comm_fpga_fx2_param.sv
// FX2LP slave-FIFO to channel-pipe bridge, generic in channel width, length-header
// size and IN endpoint packet size.
module comm_fpga_fx2_param #(
  parameter int CHAN_WIDTH   = 7,
  parameter int COUNT_BYTES  = 2,
  parameter int EP_SIZE_LOG2 = 9
) (
  input  logic      clk_in,
  input  logic      reset_n_in,
  output logic      reset_out,
  output wire       fx2FifoSel_out,
  inout  wire [7:0] fx2Data_io,
  output wire       fx2Read_out,
  input  logic      fx2GotData_in,
  output wire       fx2Write_out,
  input  logic      fx2GotRoom_in,
  output wire       fx2PktEnd_out,
  comm_fpga_fx2_param_if.master ch
);
  localparam int LOW_W = 8 * COUNT_BYTES;
  localparam int CNT_W = LOW_W + 1;

  typedef enum logic [3:0] {
    S_RESET                = 4'd0,
    S_IDLE                 = 4'd1,
    S_GET_COUNT            = 4'd2,
    S_BEGIN_WRITE          = 4'd3,
    S_WRITE                = 4'd4,
    S_END_WRITE_ALIGNED    = 4'd5,
    S_END_WRITE_NONALIGNED = 4'd6,
    S_READ                 = 4'd7
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CHAN_WIDTH-1:0] chan_q, chan_d;
  logic                  is_write_q, is_write_d;
  logic                  is_aligned_q, is_aligned_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic                  xfer_done_q, xfer_done_d;

  logic [LOW_W-1:0]      data_ext;
  logic [LOW_W-1:0]      count_low;
  logic                  in_reset;
  logic                  fifo_sel;
  logic                  fifo_read_n;
  logic                  fifo_write_n;
  logic                  pkt_end_n;
  logic                  drive_bus;
  logic                  h2f_valid;
  logic                  f2h_ready;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    chan_d       = chan_q;
    is_write_d   = is_write_q;
    is_aligned_d = is_aligned_q;
    byte_idx_d   = byte_idx_q;
    xfer_done_d  = 1'b0;
    in_reset     = 1'b0;
    fifo_sel     = 1'b0;
    fifo_read_n  = 1'b0;
    fifo_write_n = 1'b1;
    pkt_end_n    = 1'b1;
    drive_bus    = 1'b0;
    h2f_valid    = 1'b0;
    f2h_ready    = 1'b0;

    // Header bytes arrive most significant first, so each new byte enters at the LSB.
    data_ext       = '0;
    data_ext[7:0]  = fx2Data_io;
    count_low      = (count_q[LOW_W-1:0] << 8) | data_ext;

    case (state_q)
      S_RESET: begin
        in_reset = 1'b1;
        if (!fx2GotData_in) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (fx2GotData_in) begin
          chan_d     = fx2Data_io[CHAN_WIDTH-1:0];
          is_write_d = fx2Data_io[7];
          byte_idx_d = 2'd0;
          count_d    = '0;
          state_d    = S_GET_COUNT;
        end
      end

      S_GET_COUNT: begin
        if (fx2GotData_in) begin
          count_d = {1'b0, count_low};
          if (byte_idx_q == 2'(COUNT_BYTES - 1)) begin
            // An all-zero header means the maximum length, 2^(8*COUNT_BYTES).
            count_d[LOW_W] = (count_low == '0);
            state_d        = is_write_q ? S_BEGIN_WRITE : S_READ;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else begin
          fifo_read_n = 1'b1;
        end
      end

      S_BEGIN_WRITE: begin
        fifo_sel     = 1'b1;
        fifo_read_n  = 1'b1;
        is_aligned_d = (count_q[EP_SIZE_LOG2-1:0] == '0);
        state_d      = S_WRITE;
      end

      S_WRITE: begin
        fifo_sel    = 1'b1;
        fifo_read_n = 1'b1;
        f2h_ready   = fx2GotRoom_in;
        if (fx2GotRoom_in && ch.f2hValid_in) begin
          drive_bus    = 1'b1;
          fifo_write_n = 1'b0;
          count_d      = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            xfer_done_d = 1'b1;
            state_d     = is_aligned_q ? S_END_WRITE_ALIGNED : S_END_WRITE_NONALIGNED;
          end
        end
      end

      S_END_WRITE_ALIGNED: begin
        fifo_sel    = 1'b1;
        fifo_read_n = 1'b1;
        state_d     = S_IDLE;
      end

      S_END_WRITE_NONALIGNED: begin
        // A short final packet must be committed explicitly or the host never sees it.
        fifo_sel    = 1'b1;
        fifo_read_n = 1'b1;
        pkt_end_n   = 1'b0;
        state_d     = S_IDLE;
      end

      S_READ: begin
        if (fx2GotData_in && ch.h2fReady_in) begin
          h2f_valid = 1'b1;
          count_d   = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            xfer_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          fifo_read_n = 1'b1;
        end
      end

      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q      <= S_RESET;
      count_q      <= '0;
      chan_q       <= '0;
      is_write_q   <= 1'b0;
      is_aligned_q <= 1'b0;
      byte_idx_q   <= 2'd0;
      xfer_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      chan_q       <= chan_d;
      is_write_q   <= is_write_d;
      is_aligned_q <= is_aligned_d;
      byte_idx_q   <= byte_idx_d;
      xfer_done_q  <= xfer_done_d;
    end
  end

  // The FX2 control pins float while the bridge sits in reset.
  assign reset_out      = in_reset;
  assign fx2FifoSel_out = in_reset ? 1'bz : fifo_sel;
  assign fx2Read_out    = in_reset ? 1'bz : fifo_read_n;
  assign fx2Write_out   = in_reset ? 1'bz : fifo_write_n;
  assign fx2PktEnd_out  = in_reset ? 1'bz : pkt_end_n;
  assign fx2Data_io     = drive_bus ? ch.f2hData_in : 8'bz;

  assign ch.chanAddr_out = chan_q;
  assign ch.h2fData_out  = fx2Data_io;
  assign ch.h2fValid_out = h2f_valid;
  assign ch.f2hReady_out = f2h_ready;
  assign ch.xferBusy_out = (state_q != S_RESET) && (state_q != S_IDLE);
  assign ch.xferDone_out = xfer_done_q;
  assign ch.state_dbg    = state_q;
endmodule

// File: tb/tb_comm_fpga_fx2_param.sv
// Bench for comm_fpga_fx2_param: one default instance and one narrow instance
// (4-bit channel, 1-byte header, 64-byte packets) sharing a modelled FX2LP bus.
module tb_comm_fpga_fx2_param;
  localparam logic [3:0] S_RESET_V = 4'd0;
  localparam logic [3:0] S_IDLE_V  = 4'd1;
  localparam logic [3:0] S_WRITE_V = 4'd4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n0, rst_n1, which;

  // FX2 side, shared by both instances; the idle instance is held in reset
  logic       got_data, got_room, h2f_ready, f2h_valid;
  logic [7:0] host_data, f2h_data;
  wire  [7:0] fx2_data;
  wire        sel0, rd0, wr0, pe0, sel1, rd1, wr1, pe1;
  logic       ro0, ro1;

  comm_fpga_fx2_param_if #(.CHAN_WIDTH(7)) if0 ();
  comm_fpga_fx2_param_if #(.CHAN_WIDTH(4)) if1 ();

  assign if0.h2fReady_in = h2f_ready;
  assign if0.f2hData_in  = f2h_data;
  assign if0.f2hValid_in = f2h_valid;
  assign if1.h2fReady_in = h2f_ready;
  assign if1.f2hData_in  = f2h_data;
  assign if1.f2hValid_in = f2h_valid;

  comm_fpga_fx2_param dut0 (
    .clk_in(clk), .reset_n_in(rst_n0), .reset_out(ro0), .fx2FifoSel_out(sel0),
    .fx2Data_io(fx2_data), .fx2Read_out(rd0), .fx2GotData_in(got_data),
    .fx2Write_out(wr0), .fx2GotRoom_in(got_room), .fx2PktEnd_out(pe0), .ch(if0)
  );

  comm_fpga_fx2_param #(.CHAN_WIDTH(4), .COUNT_BYTES(1), .EP_SIZE_LOG2(6)) dut1 (
    .clk_in(clk), .reset_n_in(rst_n1), .reset_out(ro1), .fx2FifoSel_out(sel1),
    .fx2Data_io(fx2_data), .fx2Read_out(rd1), .fx2GotData_in(got_data),
    .fx2Write_out(wr1), .fx2GotRoom_in(got_room), .fx2PktEnd_out(pe1), .ch(if1)
  );

  wire       c_rst_n     = which ? rst_n1 : rst_n0;
  wire       c_rst_out   = which ? ro1 : ro0;
  wire       c_sel       = which ? sel1 : sel0;
  wire       c_rd        = which ? rd1 : rd0;
  wire       c_wr        = which ? wr1 : wr0;
  wire       c_pe        = which ? pe1 : pe0;
  wire       c_h2f_valid = which ? if1.h2fValid_out : if0.h2fValid_out;
  wire [7:0] c_h2f_data  = which ? if1.h2fData_out : if0.h2fData_out;
  wire       c_f2h_ready = which ? if1.f2hReady_out : if0.f2hReady_out;
  wire       c_busy      = which ? if1.xferBusy_out : if0.xferBusy_out;
  wire       c_done      = which ? if1.xferDone_out : if0.xferDone_out;
  wire [3:0] c_state     = which ? if1.state_dbg : if0.state_dbg;
  wire [6:0] c_chan      = which ? {3'b000, if1.chanAddr_out} : if0.chanAddr_out;
  wire       active      = c_rst_n && !c_rst_out;
  wire       host_drive  = c_rst_out || !c_sel;

  assign fx2_data = host_drive ? host_data : 8'bz;

  logic [7:0] out_q[$];
  logic [7:0] src_q[$];
  logic [7:0] exp_h2f_q[$];
  logic [7:0] exp_f2h_q[$];

  int   n_checks = 0;
  int   n_errs   = 0;
  int   h2f_cnt, wr_cnt, pe_cnt, done_cnt;
  logic busy_seen;
  logic pend_pop, pend_src, toggle_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // FX2LP model: commits the transfers decided last cycle, then presents new inputs.
  always @(negedge clk) begin
    logic [7:0] junk;
    if (pend_pop && out_q.size() != 0) junk = out_q.pop_front();
    if (pend_src && src_q.size() != 0) junk = src_q.pop_front();
    if (toggle_en) h2f_ready = ~h2f_ready;
    got_data  = (out_q.size() != 0);
    host_data = (out_q.size() != 0) ? out_q[0] : 8'h00;
    f2h_valid = (src_q.size() != 0);
    f2h_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    #1;
    pend_pop = active && !c_sel && !c_rd && got_data;
    pend_src = active && c_sel && c_f2h_ready && f2h_valid;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] e;
    #1;
    if (active) begin
      if (c_h2f_valid) begin
        h2f_cnt++;
        if (exp_h2f_q.size() == 0) fail_now("h2f_extra");
        else begin
          e = exp_h2f_q.pop_front();
          check("h2f_data", {24'h0, c_h2f_data}, {24'h0, e});
        end
      end
      if (c_sel && !c_wr) begin
        wr_cnt++;
        if (exp_f2h_q.size() == 0) fail_now("fx2_write_extra");
        else begin
          e = exp_f2h_q.pop_front();
          check("fx2_write_data", {24'h0, fx2_data}, {24'h0, e});
        end
      end
      if (!c_pe) pe_cnt++;
      if (c_busy) busy_seen = 1'b1;
    end
    if (c_done) done_cnt++;
  end

  // driver tasks
  task automatic push_hdr(input logic [7:0] cmd, input int nb, input logic [31:0] cnt);
    out_q.push_back(cmd);
    for (int i = nb - 1; i >= 0; i--) out_q.push_back(8'(cnt >> (8 * i)));
  endtask

  task automatic host_write(input logic [7:0] cmd, input int nb, input logic [31:0] hdr, input int n);
    push_hdr(cmd, nb, hdr);
    for (int i = 0; i < n; i++) begin
      out_q.push_back(8'(i * 37 + 5));
      exp_h2f_q.push_back(8'(i * 37 + 5));
    end
  endtask

  task automatic host_read(input logic [7:0] cmd, input int nb, input logic [31:0] hdr, input int n);
    push_hdr(cmd, nb, hdr);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(8'(i * 13 + 7));
      exp_f2h_q.push_back(8'(i * 13 + 7));
    end
  endtask

  task automatic clear_counts();
    h2f_cnt = 0; wr_cnt = 0; pe_cnt = 0; done_cnt = 0; busy_seen = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (!(c_state == S_IDLE_V && out_q.size() == 0 && src_q.size() == 0) && n < 4000);
    check({name, "_timeout"}, (n < 4000), 1);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic expect_xfer(input string name, input int h2f, input int wr, input int pe,
                             input logic [6:0] chan);
    check({name, "_h2f_count"}, h2f_cnt, h2f);
    check({name, "_write_count"}, wr_cnt, wr);
    check({name, "_pktend_cycles"}, pe_cnt, pe);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_chan"}, {25'h0, c_chan}, {25'h0, chan});
    check({name, "_busy_seen"}, busy_seen, 1);
    check({name, "_idle"}, {c_busy, c_state}, {1'b0, S_IDLE_V});
    check({name, "_exp_left"}, exp_h2f_q.size() + exp_f2h_q.size(), 0);
  endtask

  initial begin
    int n;
    which = 1'b0; rst_n0 = 1'b0; rst_n1 = 1'b0;
    got_room = 1'b1; h2f_ready = 1'b1; toggle_en = 1'b0;
    pend_pop = 1'b0; pend_src = 1'b0;
    clear_counts();

    repeat (3) @(negedge clk);
    #2;
    check("reset_out_in_reset", c_rst_out, 1);
    check("reset_state", {28'h0, c_state}, {28'h0, S_RESET_V});
    check("reset_busy", c_busy, 0);
    check("reset_done", c_done, 0);
    @(negedge clk); rst_n0 = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("idle_after_reset", {28'h0, c_state}, {28'h0, S_IDLE_V});
    check("reset_out_released", c_rst_out, 0);
    check("chan_cleared", {25'h0, c_chan}, 0);

    // host write ch 5, count 3, bytes 11 22 33, ready toggling
    @(negedge clk);
    clear_counts(); toggle_en = 1'b1;
    push_hdr(8'h05, 2, 3);
    out_q.push_back(8'h11); out_q.push_back(8'h22); out_q.push_back(8'h33);
    exp_h2f_q.push_back(8'h11); exp_h2f_q.push_back(8'h22); exp_h2f_q.push_back(8'h33);
    wait_done("hw3");
    expect_xfer("hw3", 3, 0, 0, 7'h05);
    @(negedge clk); toggle_en = 1'b0; h2f_ready = 1'b1;

    // host read of exactly one full 512-byte packet: no short-packet commit
    @(negedge clk); clear_counts();
    host_read(8'hFF, 2, 32'h0200, 512);
    wait_done("hr512");
    expect_xfer("hr512", 0, 512, 0, 7'h7F);

    // host read of 5 bytes: one PktEnd cycle
    @(negedge clk); clear_counts();
    host_read(8'h83, 2, 32'h0005, 5);
    wait_done("hr5");
    expect_xfer("hr5", 0, 5, 1, 7'h03);

    // EP6IN room removed for 10 cycles mid-transfer
    @(negedge clk); clear_counts();
    host_read(8'h81, 2, 32'h0020, 32);
    n = 0;
    do begin @(negedge clk); #2; n++; end while (wr_cnt < 10 && n < 500);
    check("stall_reach_timeout", (n < 500), 1);
    @(negedge clk); got_room = 1'b0;
    #2;
    n = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      check("stall_f2h_ready", c_f2h_ready, 0);
    end
    check("stall_no_writes", wr_cnt, n);
    check("stall_state", {28'h0, c_state}, {28'h0, S_WRITE_V});
    @(negedge clk); got_room = 1'b1;
    wait_done("hr32");
    expect_xfer("hr32", 0, 32, 1, 7'h01);

    // reset in the middle of a 120-byte host write
    @(negedge clk); clear_counts();
    host_write(8'h02, 2, 32'd120, 120);
    n = 0;
    do begin @(negedge clk); #2; n++; end while (h2f_cnt < 20 && n < 500);
    check("mid_reset_reach_timeout", (n < 500), 1);
    @(negedge clk); rst_n0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check("mid_reset_reset_out", c_rst_out, 1);
      check("mid_reset_state", {28'h0, c_state}, {28'h0, S_RESET_V});
      check("mid_reset_busy", c_busy, 0);
    end
    @(negedge clk);
    out_q.delete(); exp_h2f_q.delete();
    repeat (3) @(negedge clk);
    #2;
    check("post_reset_idle", {28'h0, c_state}, {28'h0, S_IDLE_V});
    check("post_reset_reset_out", c_rst_out, 0);
    check("post_reset_chan", {25'h0, c_chan}, 0);
    @(negedge clk); clear_counts();
    host_write(8'h06, 2, 32'd2, 2);
    wait_done("hw2");
    expect_xfer("hw2", 2, 0, 0, 7'h06);

    // narrow instance: 1-byte header, 64-byte packets, 4-bit channel
    @(negedge clk); rst_n0 = 1'b0; which = 1'b1; rst_n1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n1 = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("n_idle_after_reset", {28'h0, c_state}, {28'h0, S_IDLE_V});

    @(negedge clk); clear_counts();
    host_read(8'hDA, 1, 32'h00, 256);
    wait_done("n_hr256");
    expect_xfer("n_hr256", 0, 256, 0, 7'h0A);

    @(negedge clk); clear_counts();
    host_read(8'h85, 1, 32'h40, 64);
    wait_done("n_hr64");
    expect_xfer("n_hr64", 0, 64, 0, 7'h05);

    @(negedge clk); clear_counts();
    host_read(8'h81, 1, 32'h41, 65);
    wait_done("n_hr65");
    expect_xfer("n_hr65", 0, 65, 1, 7'h01);

    @(negedge clk); clear_counts();
    host_write(8'h03, 1, 32'h00, 256);
    wait_done("n_hw256");
    expect_xfer("n_hw256", 256, 0, 0, 7'h03);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
